seg_scan_display: RTL

//  Parametrised successor to the 4-digit score display. Takes a binary score,

---
 rtl/seg_disp_pkg.sv | 20 ++
 rtl/bin2bcd_seq.sv | 80 ++++++++
 rtl/seg_scan_display.sv | 51 +++++
 3 files changed

// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: segment patterns and converter states shared by seg_scan_display
package seg_disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0: seg_decode = 7'h40;
      4'd1: seg_decode = 7'h79;
      4'd2: seg_decode = 7'h24;
      4'd3: seg_decode = 7'h30;
      4'd4: seg_decode = 7'h19;
      4'd5: seg_decode = 7'h12;
      4'd6: seg_decode = 7'h02;
      4'd7: seg_decode = 7'h78;
      4'd8: seg_decode = 7'h00;
      4'd9: seg_decode = 7'h10;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble with atomic BCD/ovf/blank update (LEAD_ZERO_BLANK_EN adds blank mask)
module bin2bcd_seq import seg_disp_pkg::*; #(
  parameter int SCORE_W = 14,
  parameter int N_DIGITS = 4
) (
  input  logic                  segclk,
  input  logic                  clr_n,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    score,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic [N_DIGITS-1:0]   blank,
  output logic                  ovf
);
  localparam int NS = (SCORE_W + 2) / 3;
  localparam int NT = NS > N_DIGITS ? NS : N_DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [N_DIGITS-1:0] BLANK_RST = ~N_DIGITS'(1);
  logic z;
`else
  localparam logic [N_DIGITS-1:0] BLANK_RST = '0;
`endif
  conv_state_t state, state_n;
  logic [SCORE_W-1:0] sr;
  logic [4*NT-1:0] scr, adj;
  logic [CW-1:0] cnt;
  logic carry;
  logic [N_DIGITS-1:0] blank_n;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  // scratch is wide enough for any SCORE_W value; anything above N_DIGITS nibbles is overflow
  assign carry = |(scr >> (4 * N_DIGITS));
  always_comb begin
    adj = scr;
    for (int i = 0; i < NT; i++)
      adj[4*i +: 4] = scr[4*i +: 4] >= 4'd5 ? scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
  end
  always_comb begin
    blank_n = '0;
`ifdef LEAD_ZERO_BLANK_EN
    z = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      z = z && scr[4*i +: 4] == 4'd0;
      blank_n[i] = z && !carry;
    end
`endif
  end
  always_comb
    state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == CW'(SCORE_W - 1) ? DONE : SHIFT) : IDLE;
  always_ff @(posedge segclk or negedge clr_n)
    if (!clr_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge segclk or negedge clr_n)
    if (!clr_n) begin
      sr <= '0;
      scr <= '0;
      cnt <= '0;
      bcd <= '0;
      blank <= BLANK_RST;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sr <= score;
        scr <= '0;
        cnt <= '0;
      end
      if (busy) begin
        {scr, sr} <= {adj, sr} << 1;
        cnt <= cnt + 1'b1;
      end
      if (done) begin
        bcd <= carry ? {N_DIGITS{4'd9}} : scr[4*N_DIGITS-1:0];
        blank <= blank_n;
        ovf <= carry;
      end
    end
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: binary score to multiplexed 7-segment display (LEAD_ZERO_BLANK_EN blanks leading zeros)
module seg_scan_display import seg_disp_pkg::*; #(
  parameter int N_DIGITS = 4,
  parameter int SCORE_W = 14,
  parameter int REFRESH_DIV = 65536
) (
  input  logic                segclk,
  input  logic                clr_n,
  input  logic [SCORE_W-1:0]  score,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic                busy,
  output logic                ovf
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  logic [RW-1:0] rcnt;
  logic [IW-1:0] idx;
  logic [SCORE_W-1:0] last;
  logic done, start, wrap;
  logic [4*N_DIGITS-1:0] bcd;
  logic [N_DIGITS-1:0] blank;
  assign start = score != last;
  assign wrap = rcnt == RW'(REFRESH_DIV - 1);
  bin2bcd_seq #(.SCORE_W(SCORE_W), .N_DIGITS(N_DIGITS)) u_conv (
    .segclk(segclk),
    .clr_n(clr_n),
    .start(start),
    .score(score),
    .busy(busy),
    .done(done),
    .bcd(bcd),
    .blank(blank),
    .ovf(ovf)
  );
  // an and seg are both registered from the same idx, so a digit never pairs with stale data
  always_ff @(posedge segclk or negedge clr_n)
    if (!clr_n) begin
      rcnt <= '0;
      idx <= '0;
      last <= '0;
      seg <= SEG_BLANK;
      an <= '1;
    end else begin
      if (!busy && !done && start) last <= score;
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      if (wrap) idx <= idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
      an <= ~(N_DIGITS'(1) << idx);
      seg <= blank[idx] ? SEG_BLANK : seg_decode(bcd[4*idx +: 4]);
    end
endmodule
